// File: rtl/uart_rx.sv
// UART 8N1 receiver clocked by the oversampling tick; LSB-first deserialiser
// with a valid/ack holding register, framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       tick,
    input  logic       rst,
    input  logic       Rx_Serial,
    input  logic [3:0] tick_div,
    input  logic       Rx_Ack,
    output logic [7:0] Rx_Data,
    output logic       Rx_Valid,
    output logic       Rx_Active,
    output logic       Rx_Frame_Err,
    output logic       Rx_Overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [3:0]             count, count_n;
    logic [2:0]             bit_indx, bit_indx_n;
    logic [7:0]             shift, shift_n;
    logic                   active_n;
    logic                   frame_err_n;
    logic                   load;
    logic [3:0]             half;
    logic [3:0]             half_m1;
    logic [3:0]             div_m1;

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], Rx_Serial};
        end
    end

    assign rxs     = sync[SYNC_STAGES-1];
    assign half    = {1'b0, tick_div[3:1]};
    assign half_m1 = half - 4'd1;
    assign div_m1  = tick_div - 4'd1;

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            bit_indx     <= '0;
            shift        <= '0;
            Rx_Active    <= 1'b0;
            Rx_Frame_Err <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            bit_indx     <= bit_indx_n;
            shift        <= shift_n;
            Rx_Active    <= active_n;
            Rx_Frame_Err <= frame_err_n;
        end
    end

    // The stop window (tick_div + half ticks) exceeds 4 bits, so STOP runs it
    // as two phases: tick_div ticks, then half ticks, with bit_indx[0] as phase.
    always_comb begin
        state_n     = state;
        count_n     = count;
        bit_indx_n  = bit_indx;
        shift_n     = shift;
        active_n    = Rx_Active;
        frame_err_n = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                count_n    = '0;
                bit_indx_n = '0;
                active_n   = 1'b0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (count == half_m1) begin
                    count_n = '0;
                    if (!rxs) begin
                        active_n = 1'b1;
                        state_n  = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    count_n = count + 4'd1;
                end
            end
            DATA: begin
                if (count == div_m1) begin
                    count_n           = '0;
                    shift_n[bit_indx] = rxs;
                    if (bit_indx == 3'd7) begin
                        bit_indx_n = '0;
                        state_n    = STOP;
                    end else begin
                        bit_indx_n = bit_indx + 3'd1;
                    end
                end else begin
                    count_n = count + 4'd1;
                end
            end
            STOP: begin
                if (rxs) begin
                    load       = 1'b1;
                    active_n   = 1'b0;
                    count_n    = '0;
                    bit_indx_n = '0;
                    state_n    = IDLE;
                end else if (!bit_indx[0]) begin
                    if (count == div_m1) begin
                        count_n    = '0;
                        bit_indx_n = 3'd1;
                    end else begin
                        count_n = count + 4'd1;
                    end
                end else begin
                    if (count == half_m1) begin
                        frame_err_n = 1'b1;
                        active_n    = 1'b0;
                        count_n     = '0;
                        bit_indx_n  = '0;
                        state_n     = BREAK;
                    end else begin
                        count_n = count + 4'd1;
                    end
                end
            end
            BREAK: begin
                count_n    = '0;
                bit_indx_n = '0;
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                count_n    = '0;
                bit_indx_n = '0;
                active_n   = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    // A load takes priority over a coincident ack; overrun only if unacked.
    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            Rx_Data    <= '0;
            Rx_Valid   <= 1'b0;
            Rx_Overrun <= 1'b0;
        end else begin
            Rx_Overrun <= 1'b0;
            if (load) begin
                Rx_Data    <= shift;
                Rx_Valid   <= 1'b1;
                Rx_Overrun <= Rx_Valid && !Rx_Ack;
            end else if (Rx_Ack) begin
                Rx_Valid <= 1'b0;
            end
        end
    end

endmodule
